qk_score_scaler: RTL and testbench

Scaling stage directly downstream of the Qn×Knᵀ matmul in the self-attention head.
- Accepts beats of raw attention scores and divides each by 2^SHIFT (the 1/√dk scaling) with round-half-up and saturation.
- Tracks the running per-row maximum and buffers results in a 2-entry output FIFO with valid/ready backpressure.
- Its output feeds the softmax stage, which needs the row maximum for numerically safe exponentiation.

---
 rtl/self_attention_pkg.sv | 33 +++
 rtl/sync_fifo2.sv | 48 ++++
 rtl/qk_score_scaler.sv | 152 +++++++++++++++
 tb/tb_qk_score_scaler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/self_attention_pkg.sv
// Shared types and helpers for the self-attention head stages.
// Holds the stage FSM encoding and the round/saturate score helper.
package self_attention_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN
    } state_t;

    localparam int SHIFT_QK = 4;

    // Round-half-up divide by 2^sh, then clamp to a signed wout-bit range.
    function automatic logic signed [31:0] sat_round_shift(
        input logic signed [31:0] x,
        input int                 sh,
        input int                 wout
    );
        logic signed [31:0] s;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        s  = (x + (32'sd1 <<< (sh - 1))) >>> sh;
        hi = (32'sd1 <<< (wout - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (wout - 1));
        if (s > hi) begin
            s = hi;
        end else if (s < lo) begin
            s = lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO with occupancy count.
// Head entry is presented combinationally from storage.
module sync_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_push = push && (count != 2'd2);
    assign do_pop  = pop && (count != 2'd0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/qk_score_scaler.sv
// Scales raw Q*K^T scores by 2^-SHIFT with rounding and saturation,
// tracks the per-row maximum and buffers beats for the softmax stage.
module qk_score_scaler
    import self_attention_pkg::*;
#(
    parameter int WIDTH_IN      = 16,
    parameter int FRAC_WIDTH_IN = 8,
    parameter int WIDTH_OUT     = 16,
    parameter int LANES         = 8,
    parameter int SHIFT         = SHIFT_QK,
    parameter int ROW_BEATS     = 8,
    parameter int NUM_ROWS      = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         in_valid,
    input  logic [LANES*WIDTH_IN-1:0]    in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*WIDTH_OUT-1:0]   out_data,
    output logic                         out_row_last,
    output logic [WIDTH_OUT-1:0]         out_row_max,
    output logic                         busy,
    output logic                         done
);

    localparam int BW = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;
    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int DW = LANES * WIDTH_OUT;
    localparam int EW = DW + 1 + WIDTH_OUT;
    localparam logic signed [WIDTH_OUT-1:0] MOST_NEG =
        {1'b1, {(WIDTH_OUT - 1){1'b0}}};

    if (SHIFT < 1 || FRAC_WIDTH_IN >= WIDTH_IN) begin : g_bad_cfg
        $error("qk_score_scaler: invalid SHIFT or FRAC_WIDTH_IN");
    end

    state_t                      state;
    state_t                      state_next;
    logic [BW-1:0]               beat_cnt;
    logic [RW-1:0]               row_cnt;
    logic signed [WIDTH_OUT-1:0] row_max;
    logic signed [WIDTH_OUT-1:0] beat_max;
    logic signed [WIDTH_OUT-1:0] entry_max;
    logic [DW-1:0]               scaled;
    logic [1:0]                  fifo_count;
    logic [EW-1:0]               head;
    logic                        accept;
    logic                        pop;
    logic                        row_last;
    logic                        pass_last;
    logic                        pass_start;

    always_comb begin
        logic signed [31:0]          x;
        logic signed [31:0]          r;
        logic signed [WIDTH_OUT-1:0] lane;
        x        = '0;
        r        = '0;
        lane     = '0;
        scaled   = '0;
        beat_max = MOST_NEG;
        for (int i = 0; i < LANES; i++) begin
            x = {{(32 - WIDTH_IN){in_data[i*WIDTH_IN+WIDTH_IN-1]}},
                 in_data[i*WIDTH_IN +: WIDTH_IN]};
            r    = sat_round_shift(x, SHIFT, WIDTH_OUT);
            lane = r[WIDTH_OUT-1:0];
            scaled[i*WIDTH_OUT +: WIDTH_OUT] = lane;
            if (lane > beat_max) begin
                beat_max = lane;
            end
        end
    end

    assign entry_max  = (beat_max > row_max) ? beat_max : row_max;
    assign in_ready   = (state == ACTIVE) && (fifo_count < 2'd2);
    assign accept     = in_valid && in_ready;
    assign out_valid  = (fifo_count != 2'd0);
    assign pop        = out_valid && out_ready;
    assign row_last   = (beat_cnt == BW'(ROW_BEATS - 1));
    assign pass_last  = row_last && (row_cnt == RW'(NUM_ROWS - 1));
    assign pass_start = (state == IDLE) && start;
    assign busy       = (state != IDLE);

    always_comb begin
        state_next = state;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (accept && pass_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_count == 2'd0) begin
                    state_next = IDLE;
                    done       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            row_cnt  <= '0;
            row_max  <= MOST_NEG;
        end else begin
            state <= state_next;
            if (pass_start) begin
                beat_cnt <= '0;
                row_cnt  <= '0;
                row_max  <= MOST_NEG;
            end else if (accept) begin
                if (row_last) begin
                    beat_cnt <= '0;
                    row_cnt  <= row_cnt + 1'b1;
                    row_max  <= MOST_NEG;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                    row_max  <= entry_max;
                end
            end
        end
    end

    sync_fifo2 #(
        .W(EW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (accept),
        .push_data({scaled, row_last, entry_max}),
        .pop      (pop),
        .head     (head),
        .count    (fifo_count)
    );

    assign out_data     = head[EW-1 -: DW];
    assign out_row_last = head[WIDTH_OUT];
    assign out_row_max  = head[WIDTH_OUT-1:0];

endmodule

// File: tb/tb_qk_score_scaler.sv
// Randomized bench for qk_score_scaler against a queue-based reference.
// Small pass geometry keeps passes short so many of them run.
module tb_qk_score_scaler;

    localparam int WI = 16;
    localparam int FI = 8;
    localparam int WO = 16;
    localparam int LN = 8;
    localparam int SH = 4;
    localparam int RB = 2;
    localparam int NR = 2;
    localparam int DI = LN * WI;
    localparam int DO = LN * WO;
    localparam int HI = (1 << (WO - 1)) - 1;
    localparam int LO = -(1 << (WO - 1));

    localparam int M_IDLE = 0;
    localparam int M_ACT  = 1;
    localparam int M_DRN  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DI-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DO-1:0] out_data;
    logic          out_row_last;
    logic [WO-1:0] out_row_max;
    logic          busy;
    logic          done;

    qk_score_scaler #(
        .WIDTH_IN     (WI),
        .FRAC_WIDTH_IN(FI),
        .WIDTH_OUT    (WO),
        .LANES        (LN),
        .SHIFT        (SH),
        .ROW_BEATS    (RB),
        .NUM_ROWS     (NR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_row_last(out_row_last),
        .out_row_max (out_row_max),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DO-1:0] data;
        bit            last;
        logic [WO-1:0] mx;
    } ent_t;

    ent_t q[$];
    int   mst   = M_IDLE;
    int   mbeat = 0;
    int   mrow  = 0;
    int   mmax  = LO;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_pop = 0;
    int   n_done = 0;

    task automatic check(input string tag, input logic [159:0] got,
                         input logic [159:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Round half up = floor(x/2^SH + 1/2), done in real arithmetic.
    function automatic int ref_scale(input int x);
        real step;
        int  v;
        step = 2.0 ** SH;
        v    = $rtoi($floor($itor(x) / step + 0.5));
        if (v > HI) v = HI;
        if (v < LO) v = LO;
        return v;
    endfunction

    task automatic model_accept(input logic [DI-1:0] d);
        ent_t          e;
        int            bm;
        int            x;
        int            s;
        int            em;
        logic [WI-1:0] raw;
        bm = LO;
        e.data = '0;
        for (int i = 0; i < LN; i++) begin
            raw = d[i*WI +: WI];
            x   = $signed(raw);
            s   = ref_scale(x);
            e.data[i*WO +: WO] = s[WO-1:0];
            if (s > bm) bm = s;
        end
        em     = (bm > mmax) ? bm : mmax;
        e.mx   = em[WO-1:0];
        e.last = (mbeat == RB - 1);
        q.push_back(e);
        if (e.last) begin
            mmax  = LO;
            mbeat = 0;
            if (mrow == NR - 1) mst = M_DRN;
            mrow++;
        end else begin
            mmax = em;
            mbeat++;
        end
    endtask

    task automatic cycle(input bit v, input logic [DI-1:0] d,
                         input bit st, input bit rdy);
        bit exp_ir;
        bit exp_ov;
        bit exp_dn;
        int old;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        start     = st;
        out_ready = rdy;
        #1;
        exp_ir = (mst == M_ACT) && (q.size() < 2);
        exp_ov = (q.size() != 0);
        exp_dn = (mst == M_DRN) && (q.size() == 0);
        check("in_ready", in_ready, exp_ir);
        check("out_valid", out_valid, exp_ov);
        check("busy", busy, mst != M_IDLE);
        check("done", done, exp_dn);
        if (exp_ov) begin
            check("out_data", out_data, q[0].data);
            check("row_last", out_row_last, q[0].last);
            if (q[0].last) check("row_max", out_row_max, q[0].mx);
        end
        if (out_valid && out_ready) n_pop++;
        if (done) n_done++;
        old = mst;
        if (exp_ov && rdy) void'(q.pop_front());
        if (v && exp_ir) model_accept(d);
        if (old == M_IDLE && st) begin
            mst   = M_ACT;
            mbeat = 0;
            mrow  = 0;
            mmax  = LO;
        end else if (old == M_DRN && exp_dn) begin
            mst = M_IDLE;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        q.delete();
        mst = M_IDLE;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_row_last", out_row_last, 0);
        check("rst_row_max", out_row_max, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
    endtask

    function automatic logic [DI-1:0] fill(input logic [WI-1:0] v);
        logic [DI-1:0] d;
        for (int i = 0; i < LN; i++) d[i*WI +: WI] = v;
        return d;
    endfunction

    function automatic logic [DI-1:0] rand_beat();
        logic [DI-1:0] d;
        logic [WI-1:0] l;
        for (int i = 0; i < LN; i++) begin
            case ($urandom_range(0, 7))
                0:       l = 16'h7FFF;
                1:       l = 16'h8000;
                2:       l = 16'hFFF8;
                3:       l = 16'h0008;
                4:       l = 16'h0007;
                default: l = WI'($urandom);
            endcase
            d[i*WI +: WI] = l;
        end
        return d;
    endfunction

    task automatic finish_pass(input int rdy_pct, input int vld_pct);
        int n;
        n = 0;
        while (mst != M_IDLE && n < 300) begin
            cycle($urandom_range(0, 99) < vld_pct, rand_beat(),
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 99) < rdy_pct);
            n++;
        end
        if (mst != M_IDLE) check("pass_complete", busy, 0);
    endtask

    initial begin
        logic [DI-1:0] d;

        do_reset();

        // Beats offered while idle must be dropped.
        for (int i = 0; i < 3; i++) cycle(1, rand_beat(), 0, 1);

        // Row max: 5 then 3, then a fully negative row.
        cycle(0, '0, 1, 1);
        d = fill(16'h0010);
        d[2*WI +: WI] = 16'd80;
        cycle(1, d, 0, 1);
        d = fill(16'hFF00);
        d[5*WI +: WI] = 16'd48;
        cycle(1, d, 1, 1);
        cycle(1, fill(16'hF000), 0, 1);
        cycle(1, fill(16'hE800), 0, 1);
        finish_pass(100, 100);

        // Rounding and saturation on individual lanes.
        cycle(0, '0, 1, 0);
        d = fill(16'h0000);
        d[0*WI +: WI] = 16'h0018;
        d[1*WI +: WI] = 16'h0017;
        d[2*WI +: WI] = 16'hFFE8;
        d[3*WI +: WI] = 16'h7FFF;
        cycle(1, d, 0, 0);
        @(posedge clk);
        #1;
        check("lane_24", out_data[15:0], 16'h0002);
        check("lane_23", out_data[31:16], 16'h0001);
        check("lane_m24", out_data[47:32], 16'hFFFF);
        check("lane_max", out_data[63:48], 16'h0800);
        finish_pass(60, 80);

        // Backpressure: sink stalls for 5 cycles.
        cycle(0, '0, 1, 0);
        for (int i = 0; i < 5; i++) cycle(1, rand_beat(), 0, 0);
        finish_pass(100, 100);

        // Full pass at full rate.
        n_pop  = 0;
        n_done = 0;
        cycle(0, '0, 1, 1);
        finish_pass(100, 100);
        check("pass_beats", n_pop, 4);
        check("done_pulses", n_done, 1);
        cycle(0, '0, 0, 1);

        // Reset mid-row with one entry pending.
        cycle(0, '0, 1, 0);
        cycle(1, fill(16'h7FFF), 0, 0);
        do_reset();
        cycle(0, '0, 1, 1);
        cycle(1, fill(16'h0030), 0, 1);
        cycle(1, fill(16'hFFC0), 0, 1);
        finish_pass(100, 100);

        for (int p = 0; p < 40; p++) begin
            cycle($urandom_range(0, 1), rand_beat(), 1,
                  $urandom_range(0, 1));
            finish_pass($urandom_range(20, 100), $urandom_range(20, 100));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
